// File: rtl/alu_serial_tx.sv
// Serialises one ALU request (b, a, op + CRC-4) into nine 11-bit frames on sin.
// Optional feature: define ALU_TX_ERR_INJECT_EN to add inj_crc_err (flips crc bit 0).
module alu_serial_tx #(
  parameter int IDLE_GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ALU_TX_ERR_INJECT_EN
  input  logic        inj_crc_err,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        sin,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic [3:0]  crc_r;
  logic [3:0]  frm_r;
  logic [3:0]  bit_r;
  logic [3:0]  gap_r;
  logic        sin_r;
  logic        ready_r;
  logic        busy_r;

  logic        accept_s;
  logic        inj_s;
  logic [3:0]  nxt_frm_s;
  logic [3:0]  nxt_bit_s;
  logic [7:0]  frame_byte_s;
  logic [10:0] frame_bits_s;
  logic        nxt_sin_s;

  // CRC-4, x^4+x+1, zero seed, MSB first
  function automatic logic [3:0] crc4(input logic [67:0] din);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ din[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

`ifdef ALU_TX_ERR_INJECT_EN
  assign inj_s = inj_crc_err;
`else
  assign inj_s = 1'b0;
`endif

  assign accept_s  = req_valid & ready_r;
  assign req_ready = ready_r;
  assign sin       = sin_r;
  assign busy      = busy_r;

  // Position and level of the next serial bit while a packet is in flight
  always_comb begin
    nxt_frm_s = frm_r;
    nxt_bit_s = bit_r + 4'd1;
    if (bit_r == 4'd10) begin
      nxt_frm_s = frm_r + 4'd1;
      nxt_bit_s = 4'd0;
    end else begin
      nxt_frm_s = frm_r;
    end
    case (nxt_frm_s)
      4'd0:    frame_byte_s = b_r[31:24];
      4'd1:    frame_byte_s = b_r[23:16];
      4'd2:    frame_byte_s = b_r[15:8];
      4'd3:    frame_byte_s = b_r[7:0];
      4'd4:    frame_byte_s = a_r[31:24];
      4'd5:    frame_byte_s = a_r[23:16];
      4'd6:    frame_byte_s = a_r[15:8];
      4'd7:    frame_byte_s = a_r[7:0];
      4'd8:    frame_byte_s = {1'b0, op_r, crc_r};
      default: frame_byte_s = 8'hFF;
    endcase
    // Bit 10 of frame_bits_s is the start bit, bit 0 the stop bit
    frame_bits_s = {1'b0, (nxt_frm_s == 4'd8), frame_byte_s, 1'b1};
    nxt_sin_s    = frame_bits_s[4'd10 - nxt_bit_s];
  end

  // Packet state machine with registered sin, req_ready and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= 32'h0000_0000;
      b_r     <= 32'h0000_0000;
      op_r    <= 3'b000;
      crc_r   <= 4'h0;
      frm_r   <= 4'd0;
      bit_r   <= 4'd0;
      gap_r   <= 4'd0;
      sin_r   <= 1'b1;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            crc_r   <= crc4({b, a, 1'b1, op}) ^ {3'b000, inj_s};
            frm_r   <= 4'd0;
            bit_r   <= 4'd0;
            sin_r   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= SEND;
          end else begin
            sin_r   <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        SEND: begin
          if ((frm_r == 4'd8) && (bit_r == 4'd10)) begin
            sin_r   <= 1'b1;
            gap_r   <= 4'd0;
            state_r <= GAP;
          end else begin
            frm_r <= nxt_frm_s;
            bit_r <= nxt_bit_s;
            sin_r <= nxt_sin_s;
          end
        end
        GAP: begin
          sin_r <= 1'b1;
          if (gap_r == 4'(IDLE_GAP - 1)) begin
            frm_r   <= 4'd0;
            bit_r   <= 4'd0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            gap_r <= gap_r + 4'd1;
          end
        end
        default: begin
          sin_r   <= 1'b1;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_tx.sv
// Directed bench for alu_serial_tx (default IDLE_GAP=2); covers ALU_TX_ERR_INJECT_EN when defined.
module tb_alu_serial_tx;

  localparam int GAP_CYC = 2;
  localparam int SPACING = 99 + GAP_CYC + 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        sin;
  logic        busy;
`ifdef ALU_TX_ERR_INJECT_EN
  logic        inj_crc_err;
`endif

  int vectors;
  int miscompares;
  int cyc;
  int acc_t[$];

  alu_serial_tx #(.IDLE_GAP(GAP_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ALU_TX_ERR_INJECT_EN
    .inj_crc_err (inj_crc_err),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .sin         (sin),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference CRC as polynomial remainder of message*x^4 mod x^4+x+1
  function automatic logic [3:0] ref_crc(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top);
    logic [71:0] r;
    r = {tb, ta, 1'b1, top, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [10:0] exp_frame(input int f, input logic [31:0] ta, input logic [31:0] tb,
                                            input logic [2:0] top, input logic [3:0] tcrc);
    logic [7:0] d;
    if (f < 4)      d = 8'((tb >> (24 - 8 * f)) & 32'hFF);
    else if (f < 8) d = 8'((ta >> (24 - 8 * (f - 4))) & 32'hFF);
    else            d = {1'b0, top, tcrc};
    return {1'b0, (f == 8), d, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_pkt(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                         input logic [3:0] tcrc, input bit scramble, input bit drop_valid, input string tag);
    logic [98:0] bits;
    int n;
    a = ta; b = tb; op = top; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, req_ready, 1'b1);
    acc_t.push_back(cyc);
    check({tag, "_sin_T"}, sin, 1'b1);
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (i == 0 && drop_valid) req_valid = 1'b0;
      if (scramble) begin
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      end
      bits[98 - i] = sin;
      if (i == 0) check({tag, "_busy_T1"}, busy, 1'b1);
    end
    for (int f = 0; f < 9; f++)
      check($sformatf("%s_frame%0d", tag, f), bits[98 - 11 * f -: 11], exp_frame(f, ta, tb, top, tcrc));
    @(negedge clk);
    check({tag, "_sin_T100"}, sin, 1'b1);
    check({tag, "_busy_gap"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_ready_T101"}, req_ready, 1'b0);
    @(negedge clk);
    check({tag, "_ready_T102"}, req_ready, 1'b1);
    check({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0; cyc = 0;
    rst_n = 1'b0; req_valid = 1'b0;
    a = 32'h0; b = 32'h0; op = 3'b000;
`ifdef ALU_TX_ERR_INJECT_EN
    inj_crc_err = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_sin", sin, 1'b1);
    check("rst_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    // Basic packet: crc of {2, 1, 1, 000} worked by hand is 0
    run_pkt(32'h0000_0001, 32'h0000_0002, 3'b000, 4'h0, 1'b0, 1'b1, "basic");
    repeat (4) @(negedge clk);

    // Three back-to-back packets with req_valid held
    acc_t.delete();
    run_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, ref_crc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101), 1'b0, 1'b0, "b2b0");
    run_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, ref_crc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101), 1'b0, 1'b0, "b2b1");
    run_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, ref_crc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101), 1'b0, 1'b1, "b2b2");
    check("b2b_space01", 32'(acc_t[1] - acc_t[0]), 32'(SPACING));
    check("b2b_space12", 32'(acc_t[2] - acc_t[1]), 32'(SPACING));
    repeat (20) @(negedge clk);
    check("b2b_no_4th", busy, 1'b0);

    // Inputs scrambled every cycle while busy
    run_pkt(32'hA5A5_0F0F, 32'h1357_9BDF, 3'b011, ref_crc(32'hA5A5_0F0F, 32'h1357_9BDF, 3'b011), 1'b1, 1'b1, "scram");
    repeat (3) @(negedge clk);

    // Reset in the middle of frame 4
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; op = 3'b110; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready_wait", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (49) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sin", sin, 1'b1);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_ready_release", req_ready, 1'b1);
    check("mid_no_resume", sin, 1'b1);
    run_pkt(32'h0F1E_2D3C, 32'h8001_7FFE, 3'b010, ref_crc(32'h0F1E_2D3C, 32'h8001_7FFE, 3'b010), 1'b0, 1'b1, "after_rst");

`ifdef ALU_TX_ERR_INJECT_EN
    repeat (2) @(negedge clk);
    inj_crc_err = 1'b1;
    run_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b100,
            ref_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b100) ^ 4'b0001, 1'b0, 1'b1, "inject");
    inj_crc_err = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_serial_tx.md
ALU_SERIAL_TX -- requirements
Module: alu_serial_tx

Interface
REQ-001 The block SHALL have parameter IDLE_GAP, default 2, meaning the minimum number of sin=1 cycles between the stop bit of one packet and the start bit of the next (legal 1..15).
REQ-002 clk  input  1  posedge-active clock, shared with the ALU.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  an operation request is present on a, b and op.
REQ-005 req_ready  output  1  the block can accept a request this cycle.
REQ-006 a  input  32  operand A.
REQ-007 b  input  32  operand B.
REQ-008 op  input  3  operation code, passed through unchecked.
REQ-009 sin  output  1  serial stream driving the ALU sin input; idle level 1.
REQ-010 busy  output  1  high from the accept cycle until the last gap cycle.

Function
REQ-011 A request SHALL be accepted on a rising clk edge with req_valid=1 and req_ready=1; a, b and op are captured, and later input changes are ignored.
REQ-012 The state machine SHALL have states IDLE, SEND and GAP: IDLE->SEND on accept, SEND->GAP after the last bit of frame 8, and GAP->IDLE after IDLE_GAP cycles.
REQ-013 req_ready SHALL be 1 only in IDLE, and SHALL be 0 in the accept cycle's successor.
REQ-014 The first start bit SHALL appear on sin in the cycle after accept, and each bit SHALL last exactly one clk cycle.
REQ-015 Each frame SHALL be 11 bits, in this order: start=0, flag, d7..d0, stop=1.
REQ-016 Frames 0-3 SHALL be data frames (flag=0) carrying b[31:24], b[23:16], b[15:8] and b[7:0].
REQ-017 Frames 4-7 SHALL be data frames (flag=0) carrying a[31:24] down to a[7:0].
REQ-018 Frame 8 SHALL be the CTL frame (flag=1) with data {1'b0, op[2:0], crc[3:0]}.
REQ-019 crc SHALL be CRC-4, polynomial x^4+x+1, initial value 0.
REQ-020 The crc input SHALL be the 68-bit sequence {b, a, 1'b1, op}, processed MSB first.
REQ-021 The crc SHALL be computed from the captured values before frame 8 starts, either at accept or bit-serially during frames 0-7.
REQ-022 A full packet SHALL occupy 99 cycles of sin, and the next accept SHALL occur no earlier than 99+IDLE_GAP cycles after the previous accept.
REQ-023 Back-to-back requests, with req_valid held high, SHALL be spaced by exactly 99+IDLE_GAP+1 cycles between accepts.
REQ-024 sin SHALL be 1 in IDLE and GAP, with no glitches between frames: the stop bit of frame n is directly followed by the start bit of frame n+1.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force sin=1, req_ready=0, busy=0 and state IDLE, and SHALL clear the frame and bit counters and the crc.
REQ-026 After rst_n deasserts, req_ready SHALL go to 1 on the first clk edge.
REQ-027 A packet interrupted by reset SHALL be abandoned, never resumed.

Configuration
REQ-028 With macro ALU_TX_ERR_INJECT_EN defined, the block SHALL add input inj_crc_err (1 bit), captured at accept.
REQ-029 When the captured inj_crc_err is 1, the transmitted crc SHALL be the correct crc XOR 4'b0001.
REQ-030 Without ALU_TX_ERR_INJECT_EN, the port SHALL be absent and the correct crc SHALL always be sent.

Verification
REQ-031 a=0x00000001, b=0x00000002, op=3'b000, accepted at cycle T -> frames 0-2 SHALL be 0,0,00000000,1.
REQ-032 In the same packet -> frame 3 SHALL be 0,0,00000010,1, frame 7 SHALL be 0,0,00000001,1, and frame 8 SHALL be 0,1,0000,crc,1 with crc equal to the reference model's value.
REQ-033 In the same packet -> sin SHALL be 1 at cycles T and T+100, and req_ready SHALL be 1 again at T+99+IDLE_GAP+1.
REQ-034 a=0xFFFFFFFF, b=0xFFFFFFFF, op=3'b101, with req_valid held high for three packets -> exactly three accepts spaced 102 cycles apart (IDLE_GAP=2), and every CTL data byte SHALL be {0,101,crc}.
REQ-035 rst_n pulled low for 1 cycle in the middle of frame 4 of a packet -> sin=1 in the same cycle, req_ready=1 one edge after release, and the next request SHALL be sent as a complete 99-bit packet.
REQ-036 With ALU_TX_ERR_INJECT_EN and inj_crc_err=1, a=0x12345678, b=0x9ABCDEF0, op=3'b100 -> the CTL crc SHALL differ from the model in bit 0 only, and the ALU SHALL respond with a CRC error frame.
REQ-037 a, b and op changed every cycle while busy -> the transmitted data SHALL match the values captured at accept.
